// File: rtl/ring_buf_writer.sv
// Producer side of the shared ring RAM: writes incoming words at a wrapping pointer
// and publishes each written address once its data is in RAM; slot reuse is credit-gated.
module ring_buf_writer #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int OQ_DEPTH = 4
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [DATA_W-1:0] in_tdata,
   input  logic              in_tvalid,
   output logic              in_tready,
   output logic [ADDR_W-1:0] out_tdata,
   output logic              out_tvalid,
   input  logic              out_tready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_valid,
   input  logic              rel_valid,
   output logic [ADDR_W:0]   free_cnt,
   output logic              err_rel
);
   localparam int PW = $clog2(OQ_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 1;
   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] stage_addr;
   logic [DATA_W-1:0] stage_data;
   logic              stage_v;
   logic [ADDR_W-1:0] oq_mem [OQ_DEPTH];
   logic [PW-1:0]     oq_rd;
   logic [PW-1:0]     oq_wr;
   logic [CW-1:0]     oq_count;
   logic              accept;
   logic              push;
   logic              pop;

   // The staged word still needs a FIFO slot, so it counts against occupancy.
   assign in_tready  = (free_cnt != '0) &&
                       ((SW'(oq_count) + SW'(stage_v)) < SW'(OQ_DEPTH));
   assign accept     = in_tvalid & in_tready;
   assign push       = stage_v;
   assign pop        = out_tvalid & out_tready;

   assign wr_valid   = stage_v;
   assign wr_addr    = stage_addr;
   assign wr_data    = stage_data;
   assign out_tvalid = (oq_count != '0);
   assign out_tdata  = oq_mem[oq_rd];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wptr       <= '0;
         stage_v    <= 1'b0;
         stage_addr <= '0;
         stage_data <= '0;
      end else if (accept) begin
         wptr       <= wptr + 1'b1;
         stage_v    <= 1'b1;
         stage_addr <= wptr;
         stage_data <= in_tdata;
      end else begin
         stage_v    <= 1'b0;
      end
   end

   // Address is queued only on the edge where the RAM samples the data.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < OQ_DEPTH; i++) oq_mem[i] <= '0;
         oq_rd    <= '0;
         oq_wr    <= '0;
         oq_count <= '0;
      end else begin
         if (push) begin
            oq_mem[oq_wr] <= stage_addr;
            oq_wr         <= oq_wr + 1'b1;
         end
         if (pop) oq_rd <= oq_rd + 1'b1;
         case ({push, pop})
            2'b10:   oq_count <= oq_count + 1'b1;
            2'b01:   oq_count <= oq_count - 1'b1;
            default: oq_count <= oq_count;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         free_cnt <= FULL;
         err_rel  <= 1'b0;
      end else if (accept && !rel_valid) begin
         free_cnt <= free_cnt - 1'b1;
      end else if (rel_valid && !accept) begin
         if (free_cnt == FULL) err_rel  <= 1'b1;
         else                  free_cnt <= free_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ring_buf_writer.sv
// Bench for ring_buf_writer: vector table, directed corner sequences and a
// randomized run scored against a counter-level model of the ring.
module tb_ring_buf_writer;
   localparam int OQ = 4;

   logic        aclk;
   logic        aresetn;
   logic [15:0] in_tdata;
   logic        in_tvalid;
   logic        in_tready;
   logic [7:0]  out_tdata;
   logic        out_tvalid;
   logic        out_tready;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_valid;
   logic        rel_valid;
   logic [8:0]  free_cnt;
   logic        err_rel;

   ring_buf_writer #(.ADDR_W(8), .DATA_W(16), .OQ_DEPTH(OQ)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
      .rel_valid(rel_valid), .free_cnt(free_cnt), .err_rel(err_rel)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Observed traffic
   int          tb_acc;
   logic [7:0]  wq[$];
   logic [15:0] wdq[$];
   logic [7:0]  pq[$];

   // Reference model: credits and counts of accepted / emitted addresses
   bit          chk_en;
   int          m_free, m_acc, m_pop, m_pushed;
   bit          m_err, m_lastacc;
   logic [15:0] m_lastdata;
   bit          exp_rdy, exp_ov, do_acc, do_pop;

   always @(posedge aclk) if (aresetn) begin
      if (in_tvalid && in_tready) tb_acc++;
      if (wr_valid) begin wq.push_back(wr_addr); wdq.push_back(wr_data); end
      if (out_tvalid && out_tready) pq.push_back(out_tdata);
      if (chk_en) begin
         exp_rdy = (m_free != 0) && ((m_acc - m_pop) < OQ);
         exp_ov  = (m_pushed - m_pop) > 0;
         chk("rnd_in_tready", 32'(in_tready), 32'(exp_rdy));
         chk("rnd_free_cnt", 32'(free_cnt), m_free);
         chk("rnd_err_rel", 32'(err_rel), 32'(m_err));
         chk("rnd_out_tvalid", 32'(out_tvalid), 32'(exp_ov));
         chk("rnd_wr_valid", 32'(wr_valid), 32'(m_lastacc));
         if (m_lastacc) begin
            chk("rnd_wr_addr", 32'(wr_addr), (m_acc - 1) % 256);
            chk("rnd_wr_data", 32'(wr_data), 32'(m_lastdata));
         end
         if (exp_ov && out_tready) chk("rnd_out_tdata", 32'(out_tdata), m_pop % 256);
         do_acc   = in_tvalid && exp_rdy;
         do_pop   = exp_ov && out_tready;
         m_pushed = m_acc;
         if (do_acc) begin m_acc++; m_lastdata = in_tdata; end
         m_lastacc = do_acc;
         if (do_pop) m_pop++;
         if (do_acc && !rel_valid) m_free--;
         else if (rel_valid && !do_acc) begin
            if (m_free == 256) m_err = 1'b1;
            else               m_free++;
         end
      end
   end

   task automatic step();
      @(posedge aclk); #1;
   endtask

   task automatic do_reset();
      chk_en = 0; in_tvalid = 0; in_tdata = '0; out_tready = 0; rel_valid = 0;
      aresetn = 0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1;
      tb_acc = 0; wq.delete(); wdq.delete(); pq.delete();
      m_free = 256; m_acc = 0; m_pop = 0; m_pushed = 0; m_err = 0; m_lastacc = 0;
      m_lastdata = '0;
      step();
   endtask

   typedef struct {
      logic       tv;
      logic       rel;
      logic [8:0] free;
      logic       err;
      logic       wv;
      logic [7:0] wa;
   } vec_t;
   vec_t tbl[9];

   int k;
   int n0;

   initial begin
      tbl[0] = '{1'b0, 1'b1, 9'd256, 1'b1, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 1'b0, 9'd255, 1'b1, 1'b1, 8'h00};
      tbl[2] = '{1'b1, 1'b1, 9'd255, 1'b1, 1'b1, 8'h01};
      tbl[3] = '{1'b0, 1'b1, 9'd256, 1'b1, 1'b0, 8'h00};
      tbl[4] = '{1'b0, 1'b1, 9'd256, 1'b1, 1'b0, 8'h00};
      tbl[5] = '{1'b1, 1'b0, 9'd255, 1'b1, 1'b1, 8'h02};
      tbl[6] = '{1'b1, 1'b0, 9'd254, 1'b1, 1'b1, 8'h03};
      tbl[7] = '{1'b0, 1'b1, 9'd255, 1'b1, 1'b0, 8'h00};
      tbl[8] = '{1'b0, 1'b0, 9'd255, 1'b1, 1'b0, 8'h00};

      // Reset state
      do_reset();
      chk("rst_wr_valid", 32'(wr_valid), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      chk("rst_out_tvalid", 32'(out_tvalid), 0);
      chk("rst_out_tdata", 32'(out_tdata), 0);
      chk("rst_free_cnt", 32'(free_cnt), 256);
      chk("rst_err_rel", 32'(err_rel), 0);
      chk("rst_in_tready", 32'(in_tready), 1);

      // Single word
      out_tready = 1; in_tdata = 16'h0A55; in_tvalid = 1;
      step();
      in_tvalid = 0;
      chk("single_wr_valid", 32'(wr_valid), 1);
      chk("single_wr_addr", 32'(wr_addr), 0);
      chk("single_wr_data", 32'(wr_data), 32'h0A55);
      chk("single_free", 32'(free_cnt), 255);
      chk("single_early_out", 32'(out_tvalid), 0);
      step();
      chk("single_out_tvalid", 32'(out_tvalid), 1);
      chk("single_out_tdata", 32'(out_tdata), 0);
      chk("single_wr_done", 32'(wr_valid), 0);
      step();
      chk("single_popped", 32'(out_tvalid), 0);

      // Credit vector table (includes over-release from full)
      do_reset();
      out_tready = 1;
      for (int i = 0; i < 9; i++) begin
         in_tvalid = tbl[i].tv; rel_valid = tbl[i].rel; in_tdata = 16'(16'h2000 + i);
         step();
         chk("tbl_free", 32'(free_cnt), 32'(tbl[i].free));
         chk("tbl_err", 32'(err_rel), 32'(tbl[i].err));
         chk("tbl_wr_valid", 32'(wr_valid), 32'(tbl[i].wv));
         chk("tbl_in_tready", 32'(in_tready), 1);
         if (tbl[i].wv) chk("tbl_wr_addr", 32'(wr_addr), 32'(tbl[i].wa));
      end
      in_tvalid = 0; rel_valid = 0;

      // Burst with backpressure
      do_reset();
      k = 0; in_tdata = 16'h1000; in_tvalid = 1;
      for (int c = 0; c < 8; c++) begin
         step();
         k = tb_acc; in_tdata = 16'(16'h1000 + k); in_tvalid = (k < 8);
      end
      chk("burst_accepts", tb_acc, 4);
      chk("burst_in_tready", 32'(in_tready), 0);
      chk("burst_out_tvalid", 32'(out_tvalid), 1);
      chk("burst_out_hold", 32'(out_tdata), 0);
      chk("burst_writes", wq.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < wq.size()) chk("burst_wr_addr", 32'(wq[i]), i);
      out_tready = 1;
      for (int c = 0; c < 20; c++) begin
         step();
         k = tb_acc; in_tdata = 16'(16'h1000 + k); in_tvalid = (k < 8);
      end
      chk("burst_pops", pq.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < pq.size()) begin
            chk("burst_out_order", 32'(pq[i]), i);
            chk("burst_wr_data", 32'(wdq[i]), 32'h1000 + i);
         end

      // Credit exhaustion and wrap
      do_reset();
      out_tready = 1; in_tvalid = 1; in_tdata = 16'h3333;
      repeat (262) step();
      chk("exh_accepts", tb_acc, 256);
      chk("exh_free", 32'(free_cnt), 0);
      chk("exh_in_tready", 32'(in_tready), 0);
      rel_valid = 1; in_tdata = 16'hBEEF;
      chk("exh_ready_same_cycle", 32'(in_tready), 0);
      step();
      rel_valid = 0;
      chk("exh_ready_after_rel", 32'(in_tready), 1);
      chk("exh_free_one", 32'(free_cnt), 1);
      step();
      chk("exh_wrap_wr_valid", 32'(wr_valid), 1);
      chk("exh_wrap_wr_addr", 32'(wr_addr), 0);
      chk("exh_wrap_wr_data", 32'(wr_data), 32'hBEEF);
      chk("exh_free_zero", 32'(free_cnt), 0);
      step();
      chk("exh_wrap_out_tvalid", 32'(out_tvalid), 1);
      chk("exh_wrap_out_tdata", 32'(out_tdata), 0);
      in_tvalid = 0;

      // Simultaneous accept and release at free_cnt = 10
      do_reset();
      out_tready = 1; in_tvalid = 1;
      for (int c = 0; c < 300; c++) begin
         step();
         if (tb_acc >= 246) break;
      end
      in_tvalid = 0;
      chk("sim_setup_free", 32'(free_cnt), 10);
      repeat (3) step();
      n0 = wq.size();
      in_tvalid = 1; rel_valid = 1;
      repeat (5) begin
         step();
         chk("sim_free_hold", 32'(free_cnt), 10);
      end
      in_tvalid = 0; rel_valid = 0;
      repeat (2) step();
      chk("sim_writes", wq.size() - n0, 5);
      if (wq.size() > 0) chk("sim_last_addr", 32'(wq[$]), 250);
      chk("sim_err", 32'(err_rel), 0);

      // Reset mid-burst with a write in flight and 3 addresses queued
      do_reset();
      in_tvalid = 1; in_tdata = 16'h4444;
      repeat (4) step();
      in_tvalid = 0;
      chk("rmid_pre_out_tvalid", 32'(out_tvalid), 1);
      chk("rmid_pre_wr_valid", 32'(wr_valid), 1);
      aresetn = 0;
      #1;
      chk("rmid_out_tvalid", 32'(out_tvalid), 0);
      chk("rmid_wr_valid", 32'(wr_valid), 0);
      chk("rmid_free", 32'(free_cnt), 256);
      @(negedge aclk);
      aresetn = 1; out_tready = 1; in_tvalid = 1; in_tdata = 16'h5555;
      step();
      in_tvalid = 0;
      chk("rmid_next_wr_addr", 32'(wr_addr), 0);
      chk("rmid_next_wr_valid", 32'(wr_valid), 1);
      chk("rmid_next_free", 32'(free_cnt), 255);

      // Randomized run: credit-draining phase, then credit-returning phase
      do_reset();
      chk_en = 1;
      for (int c = 0; c < 2400; c++) begin
         in_tvalid  = ($urandom % 10) < 7;
         in_tdata   = 16'($urandom);
         out_tready = ($urandom % 10) < 6;
         rel_valid  = (c < 1200) ? (($urandom % 10) < 1) : (($urandom % 10) < 5);
         step();
      end
      chk_en = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
